// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core pipeline control.
//   mem_state_t : encoding of the data-SRAM wait-state FSM
//   REG_AW_DEF  : default register-file address width
//   NOP_INSTR   : instruction word loaded into IF/ID on a flush
package cpu_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state sequencer for the multi-cycle data SRAM.
//   clk, rst   : clock, asynchronous active-high reset
//   mem_req    : MEM-stage instruction performs a load or store
//   freeze_all : whole pipeline holds (request cycle plus wait cycles)
//   mem_ready  : one-cycle pulse in DONE, SRAM data valid
module mem_wait_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze_all,
  output logic mem_ready
);

  localparam logic [7:0] WCNT_LOAD = 8'(MEM_WAIT_CYCLES - 1);

  mem_state_t state;
  logic [7:0] wcnt;

  // mem_ready is registered: it is set on the WAIT->DONE transition,
  // which makes it exactly coincident with the DONE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            state <= WAIT;
            wcnt  <= WCNT_LOAD;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            state     <= DONE;
            mem_ready <= 1'b1;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
        // Unconditional return: the finished access leaves MEM this cycle,
        // so a still-high mem_req here belongs to it and must not retrigger.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational on mem_req so the request cycle itself is frozen.
  always_comb begin
    freeze_all = ~rst & (((state == IDLE) & mem_req) | (state == WAIT));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: hold/flush/bubble controls for PC,
// IF/ID and ID/EX, load-use detection, taken-branch flush, SRAM freeze
// and a saturating stall-cycle counter.
//   id_src1/id_src2/id_two_src : source operands of the instruction in ID
//   ex_dst/ex_wb_en/ex_mem_read: destination info held in ID/EX
//   branch_taken               : branch resolved taken in EX
//   mem_req                    : MEM-stage load/store
//   hold_pc, hold_ifid, flush_ifid, flush_idex, freeze_all, mem_ready
//   stall_cnt                  : saturating count of stalled cycles
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 6,
  parameter int unsigned REG_AW          = REG_AW_DEF,
  parameter int unsigned CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_wb_en,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mem_req,
  output logic              hold_pc,
  output logic              hold_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              freeze_all,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic load_use;
  logic stall_ev;

  mem_wait_fsm #(
    .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
  ) u_mem_wait_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .freeze_all(freeze_all),
    .mem_ready (mem_ready)
  );

  // Register 0 is hard-wired zero, so it never creates a dependency.
  always_comb begin
    load_use = ex_mem_read & ex_wb_en & (ex_dst != '0) &
               ((id_src1 == ex_dst) | (id_two_src & (id_src2 == ex_dst)));
  end

  // Freeze wins: EX/ID contents stay put, so branch/load-use are simply
  // re-evaluated once the freeze lifts.
  always_comb begin
    hold_pc    = 1'b0;
    hold_ifid  = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!rst && !freeze_all) begin
      if (branch_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        hold_pc    = 1'b1;
        hold_ifid  = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  always_comb begin
    stall_ev = freeze_all | (load_use & ~branch_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_ev && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, ex_dst;
  logic       id_two_src, ex_wb_en, ex_mem_read, branch_taken, mem_req;

  logic        hold_pc0, hold_ifid0, flush_ifid0, flush_idex0, freeze0, ready0;
  logic [31:0] cnt0;
  logic        hold_pc1, hold_ifid1, flush_ifid1, flush_idex1, freeze1, ready1;
  logic [31:0] cnt1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(6), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
    .hold_pc(hold_pc0), .hold_ifid(hold_ifid0), .flush_ifid(flush_ifid0),
    .flush_idex(flush_idex0), .freeze_all(freeze0), .mem_ready(ready0),
    .stall_cnt(cnt0)
  );

  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(1), .REG_AW(5), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
    .hold_pc(hold_pc1), .hold_ifid(hold_ifid1), .flush_ifid(flush_ifid1),
    .flush_idex(flush_idex1), .freeze_all(freeze1), .mem_ready(ready1),
    .stall_cnt(cnt1)
  );

  typedef struct {
    logic        hold_pc;
    logic        hold_ifid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        freeze;
    logic        ready;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, one slot per instance (0: 6-cycle SRAM, 1: 1-cycle).
  // mst: 0 idle, 1 waiting, 2 done; mb counts frozen cycles of the access.
  int          lat[2] = '{6, 1};
  int          mst[2];
  int          mb[2];
  logic [31:0] mcnt[2];

  bit last_frz[2];
  bit last_rdy[2];
  bit last_fl[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t observe(input int k);
    exp_t o;
    if (k == 0) begin
      o.hold_pc = hold_pc0; o.hold_ifid = hold_ifid0; o.flush_ifid = flush_ifid0;
      o.flush_idex = flush_idex0; o.freeze = freeze0; o.ready = ready0; o.cnt = cnt0;
    end else begin
      o.hold_pc = hold_pc1; o.hold_ifid = hold_ifid1; o.flush_ifid = flush_ifid1;
      o.flush_idex = flush_idex1; o.freeze = freeze1; o.ready = ready1; o.cnt = cnt1;
    end
    return o;
  endfunction

  function automatic exp_t model_out(input int k, input bit lu, input bit br, input bit req);
    exp_t e;
    e.freeze     = (mst[k] == 0 && req) || (mst[k] == 1);
    e.ready      = (mst[k] == 2);
    e.cnt        = mcnt[k];
    e.hold_pc    = 1'b0;
    e.hold_ifid  = 1'b0;
    e.flush_ifid = 1'b0;
    e.flush_idex = 1'b0;
    if (!e.freeze) begin
      if (br) begin
        e.flush_ifid = 1'b1;
        e.flush_idex = 1'b1;
      end else if (lu) begin
        e.hold_pc    = 1'b1;
        e.hold_ifid  = 1'b1;
        e.flush_idex = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_step(input int k, input bit lu, input bit br, input bit frz);
    if ((frz || (lu && !br)) && mcnt[k] != 32'hFFFF_FFFF) mcnt[k] = mcnt[k] + 1;
    if (frz) begin
      mb[k]++;
      mst[k] = (mb[k] == lat[k] + 1) ? 2 : 1;
    end else if (mst[k] == 2) begin
      mst[k] = 0;
      mb[k]  = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mst[k] = 0; mb[k] = 0; mcnt[k] = '0;
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                       input logic [4:0] dst, input logic wb, input logic mr,
                       input logic br, input logic req);
    exp_t e, o;
    bit   lu;
    id_src1 = s1; id_src2 = s2; id_two_src = two; ex_dst = dst;
    ex_wb_en = wb; ex_mem_read = mr; branch_taken = br; mem_req = req;
    lu = mr && wb && (dst != 0) && ((s1 == dst) || (two && (s2 == dst)));
    for (int k = 0; k < 2; k++) sb.push_back(model_out(k, lu, br, req));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      o = observe(k);
      check($sformatf("hold_pc%0d", k),    64'(o.hold_pc),    64'(e.hold_pc));
      check($sformatf("hold_ifid%0d", k),  64'(o.hold_ifid),  64'(e.hold_ifid));
      check($sformatf("flush_ifid%0d", k), 64'(o.flush_ifid), 64'(e.flush_ifid));
      check($sformatf("flush_idex%0d", k), 64'(o.flush_idex), 64'(e.flush_idex));
      check($sformatf("freeze%0d", k),     64'(o.freeze),     64'(e.freeze));
      check($sformatf("mem_ready%0d", k),  64'(o.ready),      64'(e.ready));
      check($sformatf("stall_cnt%0d", k),  64'(o.cnt),        64'(e.cnt));
      last_frz[k] = o.freeze;
      last_rdy[k] = o.ready;
      last_fl[k]  = o.flush_ifid;
      model_step(k, lu, br, e.freeze);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t o;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      o = observe(k);
      check($sformatf("rst_hold_pc%0d", k),    64'(o.hold_pc),    64'd0);
      check($sformatf("rst_hold_ifid%0d", k),  64'(o.hold_ifid),  64'd0);
      check($sformatf("rst_flush_ifid%0d", k), 64'(o.flush_ifid), 64'd0);
      check($sformatf("rst_flush_idex%0d", k), 64'(o.flush_idex), 64'd0);
      check($sformatf("rst_freeze%0d", k),     64'(o.freeze),     64'd0);
      check($sformatf("rst_ready%0d", k),      64'(o.ready),      64'd0);
      check($sformatf("rst_cnt%0d", k),        64'(o.cnt),        64'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nfrz, rdy_at, nfl;
    bit f6[16];

    // Hazard and request inputs active during reset: outputs must stay 0.
    id_src1 = 5; id_src2 = 0; id_two_src = 0; ex_dst = 5;
    ex_wb_en = 1; ex_mem_read = 1; branch_taken = 0; mem_req = 1;
    do_reset();

    // Load-use on src1, then the bubble sits in ID/EX.
    cycle(5, 0, 0, 5, 1, 1, 0, 0);
    cycle(5, 0, 0, 0, 0, 0, 0, 0);
    check("lu_cnt", 64'(cnt0), 64'd1);
    // Destination x0 never hazards.
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    // src2 only counts when the instruction reads it.
    cycle(1, 7, 0, 7, 1, 1, 0, 0);
    cycle(1, 7, 1, 7, 1, 1, 0, 0);
    idle(1);
    check("src2_cnt", 64'(cnt0), 64'd2);
    // Branch squashes the load-use; not a stall cycle.
    cycle(5, 0, 0, 5, 1, 1, 1, 0);
    check("br_cnt", 64'(cnt0), 64'd2);

    // Memory wait with mem_req held high; back-to-back access follows DONE.
    nfrz = 0; rdy_at = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      f6[i] = last_frz[0];
      if (rdy_at < 0 && last_frz[0]) nfrz++;
      if (rdy_at < 0 && last_rdy[0]) rdy_at = i;
    end
    check("frz_len", 64'(nfrz), 64'd7);
    check("rdy_at", 64'(rdy_at), 64'd7);
    check("done_unfrozen", 64'(f6[7]), 64'd0);
    check("b2b_frz", 64'(f6[8]), 64'd1);
    idle(10);
    check("mem_cnt", 64'(cnt0), 64'd16);

    // One-cycle SRAM: two frozen cycles then DONE.
    nfrz = 0; rdy_at = -1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, (i == 0) ? 1'b1 : 1'b0);
      if (rdy_at < 0 && last_frz[1]) nfrz++;
      if (rdy_at < 0 && last_rdy[1]) rdy_at = i;
    end
    check("w1_frz_len", 64'(nfrz), 64'd2);
    check("w1_rdy_at", 64'(rdy_at), 64'd2);
    idle(6);

    // Freeze dominance: branch held through WAIT, flush only on DONE.
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    nfl = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      if (last_fl[0]) nfl++;
    end
    check("dom_no_flush", 64'(nfl), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("dom_done_flush", 64'(last_fl[0]), 64'd1);
    check("dom_done_rdy", 64'(last_rdy[0]), 64'd1);
    idle(2);

    // Reset on the 3rd frozen cycle, then a fresh full access.
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    mem_req = 1;
    do_reset();
    nfrz = 0; rdy_at = -1;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, (i < 8) ? 1'b1 : 1'b0);
      if (rdy_at < 0 && last_frz[0]) nfrz++;
      if (rdy_at < 0 && last_rdy[0]) rdy_at = i;
    end
    check("rst_frz_len", 64'(nfrz), 64'd7);
    check("rst_rdy_at", 64'(rdy_at), 64'd7);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
